// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller: splits each 32-bit access into two 16-bit SRAM phases.
// Optional build macro MEM_LAST_WRITE_FWD_EN adds a last-write forwarding register for loads.
module mem_stage_sram_ctrl #(
  parameter int unsigned WORD_LEN      = 32,
  parameter int unsigned SRAM_ADDR_LEN = 18,
  parameter int unsigned BASE_ADDR     = 1024,
  parameter int unsigned WAIT_CYCLES   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     MEM_R_EN,
  input  logic                     MEM_W_EN,
  input  logic [WORD_LEN-1:0]      ALU_res,
  input  logic [WORD_LEN-1:0]      ST_value,
  output logic [WORD_LEN-1:0]      dataMem_out,
  output logic                     ready,
  output logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR,
  output logic [15:0]              SRAM_DQ_out,
  input  logic [15:0]              SRAM_DQ_in,
  output logic                     SRAM_DQ_oe,
  output logic                     SRAM_WE_N
);

  localparam int unsigned HALF_W  = 16;
  localparam int unsigned WADDR_W = SRAM_ADDR_LEN - 1;
  localparam int unsigned CNT_W   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [WADDR_W-1:0]  r_word;
  logic [WORD_LEN-1:0] r_st;
  logic                r_wr;
  logic [HALF_W-1:0]   r_lo;

  logic                w_req;
  logic                w_last;
  logic [WADDR_W-1:0]  w_word;
  logic                w_fwd_hit;
  logic [WORD_LEN-1:0] w_fwd_data;

  // Word index relative to BASE_ADDR, wrapping modulo 2^WORD_LEN, truncated to the SRAM space
  assign w_word = WADDR_W'((ALU_res - WORD_LEN'(BASE_ADDR)) >> 2);
  assign w_req  = MEM_R_EN | MEM_W_EN;
  assign w_last = (r_cnt == CNT_W'(WAIT_CYCLES - 1));
  assign ready  = ((r_state == S_IDLE) & ~MEM_R_EN & ~MEM_W_EN) | (r_state == S_DONE);

`ifdef MEM_LAST_WRITE_FWD_EN
  logic                r_fwd_vld;
  logic [WADDR_W-1:0]  r_fwd_word;
  logic [WORD_LEN-1:0] r_fwd_data;
  logic                w_wr_done;

  assign w_wr_done  = (r_state == S_HI) & w_last & r_wr;
  assign w_fwd_hit  = MEM_R_EN & ~MEM_W_EN & r_fwd_vld & (r_fwd_word == w_word);
  assign w_fwd_data = r_fwd_data;

  // Remembers the most recently completed store so a matching load can skip the SRAM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_vld  <= 1'b0;
      r_fwd_word <= '0;
      r_fwd_data <= '0;
    end else if (w_wr_done) begin
      r_fwd_vld  <= 1'b1;
      r_fwd_word <= r_word;
      r_fwd_data <= r_st;
    end
  end
`else
  assign w_fwd_hit  = 1'b0;
  assign w_fwd_data = '0;
`endif

  // Access sequencer; SRAM pins are loaded one cycle ahead of the phase they belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_word      <= '0;
      r_st        <= '0;
      r_wr        <= 1'b0;
      r_lo        <= '0;
      dataMem_out <= '0;
      SRAM_ADDR   <= '0;
      SRAM_DQ_out <= '0;
      SRAM_DQ_oe  <= 1'b0;
      SRAM_WE_N   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fwd_hit) begin
            dataMem_out <= w_fwd_data;
            r_state     <= S_DONE;
          end else if (w_req) begin
            r_word      <= w_word;
            r_st        <= ST_value;
            r_wr        <= MEM_W_EN;
            r_cnt       <= '0;
            SRAM_ADDR   <= {w_word, 1'b0};
            SRAM_DQ_out <= ST_value[HALF_W-1:0];
            SRAM_DQ_oe  <= MEM_W_EN;
            SRAM_WE_N   <= ~MEM_W_EN;
            r_state     <= S_LO;
          end
        end
        S_LO: begin
          if (w_last) begin
            r_lo        <= SRAM_DQ_in;
            r_cnt       <= '0;
            SRAM_ADDR   <= {r_word, 1'b1};
            SRAM_DQ_out <= r_st[2*HALF_W-1:HALF_W];
            r_state     <= S_HI;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_HI: begin
          if (w_last) begin
            if (!r_wr) begin
              dataMem_out <= WORD_LEN'({SRAM_DQ_in, r_lo});
            end
            r_cnt      <= '0;
            SRAM_DQ_oe <= 1'b0;
            SRAM_WE_N  <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a 64-halfword behavioural SRAM.
module tb_mem_stage_sram_ctrl;

`ifdef MEM_LAST_WRITE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_res;
  logic [31:0] ST_value;
  logic [31:0] dataMem_out;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out;
  logic [15:0] SRAM_DQ_in;
  logic        SRAM_DQ_oe;
  logic        SRAM_WE_N;

  mem_stage_sram_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .MEM_R_EN    (MEM_R_EN),
    .MEM_W_EN    (MEM_W_EN),
    .ALU_res     (ALU_res),
    .ST_value    (ST_value),
    .dataMem_out (dataMem_out),
    .ready       (ready),
    .SRAM_ADDR   (SRAM_ADDR),
    .SRAM_DQ_out (SRAM_DQ_out),
    .SRAM_DQ_in  (SRAM_DQ_in),
    .SRAM_DQ_oe  (SRAM_DQ_oe),
    .SRAM_WE_N   (SRAM_WE_N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: async read, write on clock while WE_N low and driven
  logic [15:0] sram [64];
  logic        poke_en;
  logic [5:0]  poke_a;
  logic [15:0] poke_d;
  int          n_we;

  assign SRAM_DQ_in = sram[SRAM_ADDR[5:0]];

  always @(posedge clk) begin
    if (poke_en) begin
      sram[poke_a] <= poke_d;
    end else if (!SRAM_WE_N && SRAM_DQ_oe) begin
      sram[SRAM_ADDR[5:0]] <= SRAM_DQ_out;
    end
    if (!SRAM_WE_N) n_we <= n_we + 1;
  end

  int n_pass;
  int n_checks;

  logic [17:0] a_log  [8];
  logic [15:0] d_log  [8];
  logic        we_log [8];
  logic        oe_log [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [5:0] a, input logic [15:0] d);
    poke_a  = a;
    poke_d  = d;
    poke_en = 1'b1;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic idle_inputs();
    tick();
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
  endtask

  // Presents one request on the cycle after the current one; returns in the ready-high cycle
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, output int low, output logic [31:0] dout);
    bit done;
    tick();
    MEM_R_EN = rd;
    MEM_W_EN = wr;
    ALU_res  = addr;
    ST_value = data;
    #1;
    low  = 0;
    done = 1'b0;
    for (int i = 0; i < 24 && !done; i++) begin
      if (i < 8) begin
        a_log[i]  = SRAM_ADDR;
        d_log[i]  = SRAM_DQ_out;
        we_log[i] = SRAM_WE_N;
        oe_log[i] = SRAM_DQ_oe;
      end
      if (ready) done = 1'b1;
      else begin
        low++;
        tick();
      end
    end
    if (!done) check("ready_timeout", {31'd0, ready}, 32'd1);
    dout = dataMem_out;
  endtask

  int          low;
  logic [31:0] dout;
  int          we_base;
  int          exp_rd_low;

  initial begin
    n_pass   = 0;
    n_checks = 0;
    n_we     = 0;
    poke_en  = 1'b0;
    poke_a   = '0;
    poke_d   = '0;
    rst      = 1'b1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    ALU_res  = '0;
    ST_value = '0;
    exp_rd_low = FWD ? 1 : 3;

    // Reset held across preload pokes
    tick();
    tick();
    poke(6'd8,  16'hCAFE);
    poke(6'd9,  16'h0BAD);
    poke(6'd62, 16'h3333);
    poke(6'd63, 16'h4444);
    rst = 1'b0;
    #1;
    check("rst_we_n",  {31'd0, SRAM_WE_N},  32'd1);
    check("rst_oe",    {31'd0, SRAM_DQ_oe}, 32'd0);
    check("rst_dout",  dataMem_out,         32'd0);
    check("rst_ready", {31'd0, ready},      32'd1);
    check("rst_addr",  32'(SRAM_ADDR),      32'd0);

    // Store 0xDEADBEEF to 1028 -> halfwords 2 and 3
    do_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, low, dout);
    check("w_low",     32'(low),            32'd3);
    check("w_lo_addr", 32'(a_log[1]),       32'd2);
    check("w_lo_dq",   32'(d_log[1]),       32'h0000BEEF);
    check("w_lo_we",   {31'd0, we_log[1]},  32'd0);
    check("w_lo_oe",   {31'd0, oe_log[1]},  32'd1);
    check("w_hi_addr", 32'(a_log[2]),       32'd3);
    check("w_hi_dq",   32'(d_log[2]),       32'h0000DEAD);
    check("w_hi_we",   {31'd0, we_log[2]},  32'd0);
    check("w_done_we", {31'd0, we_log[3]},  32'd1);
    idle_inputs();
    #1;
    check("w_ready_after", {31'd0, ready},  32'd1);
    check("w_sram2",   32'(sram[2]),        32'h0000BEEF);
    check("w_sram3",   32'(sram[3]),        32'h0000DEAD);

    // Load back 1028
    do_access(1'b1, 1'b0, 32'd1028, 32'h0, low, dout);
    check("r_low",  32'(low), 32'(exp_rd_low));
    check("r_dout", dout,     32'hDEADBEEF);
    idle_inputs();

    // Load preloaded 1040 -> halfwords 8/9, always through the SRAM
    do_access(1'b1, 1'b0, 32'd1040, 32'h0, low, dout);
    check("r2_low",   32'(low),           32'd3);
    check("r2_dout",  dout,               32'h0BADCAFE);
    check("r2_oe",    {31'd0, oe_log[1]}, 32'd0);
    check("r2_we",    {31'd0, we_log[1]}, 32'd1);
    idle_inputs();

    // A store must not disturb the held load data
    do_access(1'b0, 1'b1, 32'd1044, 32'h11112222, low, dout);
    check("hold_done", dout, 32'h0BADCAFE);
    idle_inputs();
    tick();
    check("hold_idle", dataMem_out, 32'h0BADCAFE);
    check("w2_sram10", 32'(sram[10]), 32'h00002222);

    // Back-to-back load then store, no idle gap
    we_base = n_we;
    do_access(1'b1, 1'b0, 32'd1028, 32'h0, low, dout);
    check("b2b_r_low",  32'(low), 32'd3);
    check("b2b_r_dout", dout,     32'hDEADBEEF);
    do_access(1'b0, 1'b1, 32'd1048, 32'hA5A55A5A, low, dout);
    check("b2b_w_low",     32'(low),        32'd3);
    check("b2b_w_idleaddr", 32'(a_log[1]),  32'd12);
    check("b2b_strobes",   32'(n_we - we_base), 32'd2);
    idle_inputs();
    tick();
    tick();
    check("b2b_ready_idle", {31'd0, ready},       32'd1);
    check("b2b_no_repeat",  32'(n_we - we_base),  32'd2);
    check("b2b_sram12",     32'(sram[12]),        32'h00005A5A);
    check("b2b_sram13",     32'(sram[13]),        32'h0000A5A5);

    // Address below BASE_ADDR wraps to the top of the SRAM
    do_access(1'b1, 1'b0, 32'd1020, 32'h0, low, dout);
    check("wrap_lo_addr", 32'(a_log[1]), 32'h0003FFFE);
    check("wrap_hi_addr", 32'(a_log[2]), 32'h0003FFFF);
    check("wrap_dout",    dout,          32'h44443333);
    idle_inputs();

    // Both enables high behaves as a store
    do_access(1'b1, 1'b1, 32'd1064, 32'h0F0F1234, low, dout);
    check("rw_low",  32'(low),           32'd3);
    check("rw_oe",   {31'd0, oe_log[1]}, 32'd1);
    check("rw_dout", dout,               32'h44443333);
    idle_inputs();
    #1;
    check("rw_sram20", 32'(sram[20]), 32'h00001234);

    // Reset during the high phase of a store
    tick();
    MEM_W_EN = 1'b1;
    ALU_res  = 32'd1056;
    ST_value = 32'h77778888;
    tick();
    tick();
    check("abort_hi_we", {31'd0, SRAM_WE_N}, 32'd0);
    rst      = 1'b1;
    MEM_W_EN = 1'b0;
    tick();
    check("abort_we_n",  {31'd0, SRAM_WE_N},  32'd1);
    check("abort_oe",    {31'd0, SRAM_DQ_oe}, 32'd0);
    check("abort_ready", {31'd0, ready},      32'd1);
    check("abort_dout",  dataMem_out,         32'd0);
    check("abort_sram16", 32'(sram[16]),      32'h00008888);
    rst = 1'b0;
    tick();
    check("abort_ready2", {31'd0, ready}, 32'd1);

    // Store then overwrite the low SRAM half behind the controller's back, then load
    do_access(1'b0, 1'b1, 32'd1032, 32'h12345678, low, dout);
    idle_inputs();
    poke(6'd4, 16'hFFFF);
    we_base = n_we;
    do_access(1'b1, 1'b0, 32'd1032, 32'h0, low, dout);
    check("fwd_low",  32'(low), 32'(exp_rd_low));
    check("fwd_dout", dout,     FWD ? 32'h12345678 : 32'h1234FFFF);
    check("fwd_no_we", 32'(n_we - we_base), 32'd0);
    idle_inputs();
    tick();
    check("fwd_hold", dataMem_out, FWD ? 32'h12345678 : 32'h1234FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
